mod53_horner_seq: RTL and testbench

Sequencer that evaluates a polynomial over GF(53) at the fixed point CONST by Horner's rule: acc = acc*CONST + a_k (mod 53), with coefficients streamed highest-order first.
- Reuses one combinational mod-53 constant-multiplier unit per step and adds a mod-53 adder plus accumulator.
- Sits between a coefficient producer and a result consumer, using valid/ready handshakes on both sides.
- Is the control layer that sequences the constant-multiply LUT datapath of the mod-53 calculator.

---
 rtl/mod53_pkg.sv | 25 ++
 rtl/mod53_horner_seq_if.sv | 22 ++
 rtl/mod53_mul_const.sv | 19 +
 rtl/mod53_horner_seq.sv | 71 +++++++
 tb/tb_mod53_horner_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mod53_pkg.sv
// Shared constants, types and residue helpers for the mod-53 Horner sequencer.
package mod53_pkg;

  localparam int unsigned MOD   = 53;
  localparam int unsigned W     = 6;
  localparam int unsigned CONST = 28;
  localparam int unsigned CNT_W = 5;

  typedef logic [W-1:0] residue_t;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  // Inputs 0..63 fold into 0..52 with one subtract (63-53 < 53).
  function automatic residue_t mod_reduce6(input residue_t x);
    return (x >= W'(MOD)) ? residue_t'(x - W'(MOD)) : x;
  endfunction

  function automatic residue_t mod_add(input residue_t a, input residue_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(MOD)) s = s - (W+1)'(MOD);
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/mod53_horner_seq_if.sv
// Coefficient-in and result-out valid/ready channels of the Horner sequencer.
interface mod53_horner_seq_if;
  import mod53_pkg::*;

  logic     coef_valid;
  residue_t coef_data;
  logic     coef_ready;
  logic     res_valid;
  residue_t res_data;
  logic     res_ready;

  modport master (
    output coef_valid, coef_data, res_ready,
    input  coef_ready, res_valid, res_data
  );

  modport slave (
    input  coef_valid, coef_data, res_ready,
    output coef_ready, res_valid, res_data
  );

endinterface

// File: rtl/mod53_mul_const.sv
// Combinational residue * CONST mod MOD, built as a 64-entry table on the 6-bit input.
module mod53_mul_const
  import mod53_pkg::*;
(
  input  residue_t a_i,
  output residue_t p_o
);

  residue_t lut [2**W];

  // Entries above MOD-1 are unreachable from the accumulator but kept defined.
  for (genvar gi = 0; gi < 2**W; gi++) begin : g_lut
    localparam int unsigned PROD = (gi * CONST) % MOD;
    assign lut[gi] = W'(PROD);
  end

  assign p_o = lut[a_i];

endmodule

// File: rtl/mod53_horner_seq.sv
// Horner evaluator over GF(53) at CONST: acc = acc*CONST + a_k per accepted coefficient.
module mod53_horner_seq
  import mod53_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_terms,
  mod53_horner_seq_if.slave  bus,
  output logic               busy
);

  state_e             state_q, state_d;
  residue_t           acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  residue_t           mul_p;

  mod53_mul_const u_mul (
    .a_i (acc_q),
    .p_o (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (num_terms != '0) begin
            cnt_d   = num_terms;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // coef_ready is high throughout LOAD, so coef_valid alone marks a beat.
        if (bus.coef_valid) begin
          acc_d = mod_add(mul_p, mod_reduce6(bus.coef_data));
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.coef_ready = (state_q == LOAD);
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_data   = (state_q == DONE) ? acc_q : '0;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mod53_horner_seq.sv
// Directed and random jobs for the mod-53 Horner sequencer, checked against a scoreboard.
module tb_mod53_horner_seq;
  import mod53_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             busy;

  mod53_horner_seq_if bus ();

  mod53_horner_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .bus       (bus.slave),
    .busy      (busy)
  );

  residue_t mul_a;
  residue_t mul_p;

  mod53_mul_const u_mul_chk (
    .a_i (mul_a),
    .p_o (mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int coefs[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input int n);
    int acc = 0;
    int r;
    for (int i = 0; i < n; i++) begin
      r = (coefs[i] >= 53) ? coefs[i] - 53 : coefs[i];
      acc = (acc * 28 + r) % 53;
    end
    return acc;
  endfunction

  task automatic run_job(input int n, input bit gap, input int hold);
    int beats = 0;
    int exp_v;
    exp_q.push_back(model(n));
    num_terms = CNT_W'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_coef_ready", bus.coef_ready, 0);
    end else begin
      chk("load_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
        if (gap && i > 0) begin
          bus.coef_valid = 1'b0;
          tick();
          chk("gap_coef_ready", bus.coef_ready, 1);
          chk("gap_res_valid", bus.res_valid, 0);
        end
        bus.coef_valid = 1'b1;
        bus.coef_data  = residue_t'(coefs[i]);
        if (bus.coef_ready) beats++;
        tick();
      end
      bus.coef_valid = 1'b0;
      chk("beat_count", beats, n);
    end
    chk("latency_res_valid", bus.res_valid, 1);
    chk("done_coef_ready", bus.coef_ready, 0);
    exp_v = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      start     = 1'b1;
      num_terms = CNT_W'(3);
      tick();
      chk("hold_res_valid", bus.res_valid, 1);
      chk("hold_res_data", bus.res_data, exp_v);
    end
    start = 1'b0;
    chk("res_data", bus.res_data, exp_v);
    $display("job n=%0d gap=%0d hold=%0d res=%0d exp=%0d", n, gap, hold, bus.res_data, exp_v);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_res_valid", bus.res_valid, 0);
    chk("post_res_data", bus.res_data, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    num_terms      = '0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.res_ready  = 1'b0;
    mul_a          = '0;

    for (int x = 0; x < 53; x++) begin
      mul_a = residue_t'(x);
      #1;
      chk("mul_const", mul_p, (x * 28) % 53);
    end

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_coef_ready", bus.coef_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    coefs[0] = 1;  coefs[1] = 0;
    run_job(2, 1'b0, 0);
    coefs[0] = 1;  coefs[1] = 0;  coefs[2] = 0;
    run_job(3, 1'b0, 0);
    coefs[0] = 52; coefs[1] = 52;
    run_job(2, 1'b1, 0);
    coefs[0] = 60;
    run_job(1, 1'b0, 0);
    run_job(0, 1'b0, 0);
    coefs[0] = 1;  coefs[1] = 1;
    run_job(2, 1'b0, 5);

    // Abort a job after one of three coefficients.
    num_terms = CNT_W'(3);
    start     = 1'b1;
    tick();
    start          = 1'b0;
    bus.coef_valid = 1'b1;
    bus.coef_data  = residue_t'(1);
    tick();
    bus.coef_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_coef_ready", bus.coef_ready, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_res_data", bus.res_data, 0);
    $display("job aborted by reset after 1 of 3 coefficients");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    coefs[0] = 2;  coefs[1] = 3;
    run_job(2, 1'b0, 0);

    for (int j = 0; j < 4; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) coefs[i] = int'($urandom_range(0, 63));
      run_job(n, bit'(j & 1), j);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
